// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Request/result bundle between the execute stage and the multiply/divide
//   sequencer that owns the HI/LO register pair.
//
//   Handshake: `start` is a request strobe and `busy` is the inverted ready.
//   An operation transfers at a rising clk edge where start=1 and busy=0.
//   When busy=1, start is ignored and not queued. op/a/b only need to be
//   valid in that transfer cycle. `done` pulses for one cycle once HI/LO hold
//   the new result. wr_hi/wr_lo (MTHI/MTLO) only take effect in an idle
//   cycle with start=0.
//
//   Signals (master = requester, slave = sequencer):
//     start  m->s  1   operation request strobe
//     op     m->s  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a      m->s  32  multiplicand / dividend
//     b      m->s  32  multiplier / divisor
//     wr_hi  m->s  1   MTHI write enable
//     wr_lo  m->s  1   MTLO write enable
//     wdata  m->s  32  MTHI/MTLO data
//     busy   s->m  1   operation in flight, HI/LO not valid
//     done   s->m  1   one-cycle pulse, HI/LO just updated by an operation
//     hi     s->m  32  HI register
//     lo     s->m  32  LO register
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Multiplies use
//   shift-add (one multiplier bit per cycle), divides use restoring radix-2
//   (one quotient bit per cycle). Signed ops run on magnitudes and the signs
//   are applied in a final FIX cycle. 34-cycle issue interval.
//
//   Optional feature macro: MULDIV_FAST_MULT_EN. When defined, MULT/MULTU
//   complete in one cycle through a 64-bit multiplier and never raise busy;
//   divides are unchanged.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     bus        slave modport of muldiv_ctrl_if (request, MTHI/MTLO, results)
//     dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 FIX)
module muldiv_ctrl (
  input  logic           clk,
  input  logic           reset,
  muldiv_ctrl_if.slave   bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // Multiply: acc[31:0] holds the shrinking multiplier, acc[63:32] the
  // partial product; opnd is the multiplicand magnitude.
  // Divide: acc[31:0] shifts dividend bits out at the top and quotient bits
  // in at the bottom; opnd is the divisor magnitude.
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [32:0] rem;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic        div_zero;

  logic        signed_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [33:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_p;

  always_comb begin
    fast_p = '0;
    if (bus.op[0]) begin
      fast_p = {32'd0, bus.a} * {32'd0, bus.b};
    end else begin
      fast_p = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    end
  end
`endif

  always_comb begin
    signed_op = ~bus.op[0];
    abs_a     = (signed_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    abs_b     = (signed_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

    // rem never exceeds the divisor, so div_shift stays below 2^33 and
    // bit 33 of the trial difference is a reliable borrow flag.
    div_shift = {rem, acc[31]};
    div_trial = div_shift - {2'd0, opnd};

    prod      = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;

    fix_hi    = prod[63:32];
    fix_lo    = prod[31:0];
    if (is_div) begin
      fix_hi = neg_a ? (32'd0 - rem[31:0]) : rem[31:0];
      fix_lo = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
      // Divide by zero: quotient forced to all ones; the remainder path
      // already returns the dividend with its own sign.
      if (div_zero) begin
        fix_lo = 32'hFFFF_FFFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      rem      <= 33'd0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
`ifdef MULDIV_FAST_MULT_EN
            if (!bus.op[1]) begin
              hi_r   <= fast_p[63:32];
              lo_r   <= fast_p[31:0];
              done_r <= 1'b1;
            end else begin
`endif
              is_div   <= bus.op[1];
              neg_a    <= signed_op & bus.a[31];
              neg_b    <= signed_op & bus.b[31];
              div_zero <= (bus.b == 32'd0);
              rem      <= 33'd0;
              cnt      <= 6'd32;
              busy_r   <= 1'b1;
              state    <= RUN;
              if (bus.op[1]) begin
                acc  <= {32'd0, abs_a};
                opnd <= abs_b;
              end else begin
                acc  <= {32'd0, abs_b};
                opnd <= abs_a;
              end
`ifdef MULDIV_FAST_MULT_EN
            end
`endif
          end else begin
            if (bus.wr_hi) hi_r <= bus.wdata;
            if (bus.wr_lo) lo_r <= bus.wdata;
          end
        end

        RUN: begin
          if (is_div) begin
            if (div_trial[33]) begin
              rem <= div_shift[32:0];
              acc <= {acc[63:32], acc[30:0], 1'b0};
            end else begin
              rem <= div_trial[32:0];
              acc <= {acc[63:32], acc[30:0], 1'b1};
            end
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= FIX;
          end
        end

        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl. Inputs are driven and outputs sampled on
//   the falling clock edge. Expected HI/LO results are hand-computed and
//   queued before each operation, then popped when done is seen.
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;
  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: issue, optionally interfere with start/wr_hi while busy,
  // wait (bounded) for done, then compare latency and results.
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit wr_both, input bit interfere);
    int lat;
    int k;
    logic [63:0] exp_v;
    lat = op_i[1] ? DIV_LAT : MUL_LAT;
    exp_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    if (wr_both) begin
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    k = 1;
    check({tag, "_busy"}, {63'd0, bus.busy}, {63'd0, (lat > 1)});
    while (!bus.done && k < 100) begin
      if (interfere && k == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hFFFF_0000;
      end else begin
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
      end
      if (k == 10) begin
        check({tag, "_hold"}, {bus.hi, bus.lo}, {cur_hi, cur_lo});
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    exp_v = exp_q.pop_front();
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_v[63:32]});
    check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_v[31:0]});
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    check({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = 32'd0;
    cur_hi    = 32'd0;
    cur_lo    = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_done",  {63'd0, bus.done}, 64'd0);
    check("rst_hi",    {32'd0, bus.hi}, 64'd0);
    check("rst_lo",    {32'd0, bus.lo}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;

    // MTHI + MTLO together
    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    check("mt_both_hi", {32'd0, bus.hi}, 64'h1234_5678);
    check("mt_both_lo", {32'd0, bus.lo}, 64'h1234_5678);

    // MTLO alone
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("mt_lo_hi", {32'd0, bus.hi}, 64'h1234_5678);
    check("mt_lo_lo", {32'd0, bus.lo}, 64'h0BAD_F00D);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h0BAD_F00D;

    // write in the start cycle is dropped, op runs: 6*7 = 42
    run_op("mt_start", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0);

    // MULT -2 * 3 = -6
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    // MULTU max * max
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    // MULT min * min = 2^62
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    // DIV -7 / 2 = -3 rem -1
    run_op("div_neg_a", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    // DIV 7 / -2 = -3 rem 1
    run_op("div_neg_b", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    // DIVU 7 / 0
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // DIV -7 / 0: HI returns the dividend
    run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // DIV overflow
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    // DIVU 100 / 7 = 14 rem 2, with start and MTHI attempted while busy
    run_op("divu_ign", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

    // reset in the middle of a DIV
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  {63'd0, bus.busy}, 64'd0);
    check("abort_done",  {63'd0, bus.done}, 64'd0);
    check("abort_hi",    {32'd0, bus.hi}, 64'd0);
    check("abort_lo",    {32'd0, bus.lo}, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    reset  = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    run_op("post_abort", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
